sma_window_ctrl: RTL and testbench
==================================

Name: sma_window_ctrl

Overview:
- Sequencer in front of the FOG/PIG simple-moving-average filter (power-of-two window, 2^sel samples, circular sample memory with no reset).
- Owns the filter's window-select and update-strobe inputs.
- On power-up and on every window change it zero-flushes the sample memory, re-homes the filter's write pointer to 0 and switches the window.
- It then primes the new window and flags output valid once 2^sel real samples have been accumulated.

Parameters:
- MAX_SEL, 15, largest window select; filter depth = 2^MAX_SEL; must match filter WINDOW_SIZE.
- SETTLE_CYC, 3, idle cycles after any o_window_sel change before the first strobe; covers the filter's 2-cycle select-to-N pipeline.
- CNT_W, 17, width of internal strobe/prime counters; must be ≥ MAX_SEL+2.

Ports:
- i_clk  in  1  system clock.
- i_rst_n  in  1  asynchronous active-low reset; the same net resets the filter.
- i_window_sel  in  32  requested window select 0..MAX_SEL; values > MAX_SEL clamp to MAX_SEL.
- i_update_strobe  in  1  new-sample strobe from the upstream datapath.
- i_data  in  32 signed  upstream sample.
- o_window_sel  out  32  window select driven to the filter.
- o_update_strobe  out  1  strobe driven to the filter.
- o_data  out  32 signed  sample driven to the filter.
- o_busy  out  1  high in SETUP, FLUSH and APPLY.
- o_valid  out  1  filter output is a full-window average.

Behaviour:
- Clock/reset: one clock i_clk; asynchronous active-low reset i_rst_n.
- Reset values: state=SETUP; o_window_sel=MAX_SEL; o_update_strobe=0; o_data=0; o_busy=1; o_valid=0; ptr=0; active_sel=0.
- Internal ptr mirrors the filter's write index. On every issued strobe: ptr <= (ptr==2^cur_sel-1) ? 0 : ptr+1, where cur_sel = o_window_sel as seen by the filter.
- SETUP:
  - o_window_sel=MAX_SEL; wait SETTLE_CYC cycles.
  - Then load flush_len = 2^MAX_SEL + ((2^MAX_SEL - ptr) mod 2^MAX_SEL) and go to FLUSH.
- FLUSH:
  - One strobe per clock: o_update_strobe=1, o_data=0.
  - After flush_len strobes (every entry written to 0, ptr==0, filter sum==0) latch target_sel and go to APPLY.
- APPLY:
  - o_window_sel=target_sel; no strobes for SETTLE_CYC cycles.
  - Then active_sel=target_sel, prime_cnt=0, go to PRIME.
- PRIME:
  - o_update_strobe=i_update_strobe and o_data=i_data, both registered (1-cycle latency).
  - prime_cnt increments per strobe; when prime_cnt reaches 2^active_sel go to RUN and set o_valid=1 in the same cycle as the last forwarded strobe.
- RUN:
  - Pass-through as in PRIME; o_valid=1.
- Window change:
  - In PRIME or RUN, clamped i_window_sel != active_sel → o_valid=0 next cycle, go to SETUP.
  - A strobe arriving in that same cycle is still forwarded.
- Dropped samples: upstream strobes during SETUP, FLUSH or APPLY are discarded; upstream is not back-pressured.
- Requests during flush: a request changing during SETUP or FLUSH is taken at APPLY entry (last value wins). A change during APPLY is detected in PRIME and triggers a fresh flush.
- target_sel=0 (window 1): prime length 1; o_valid goes high with the first forwarded strobe.
- Reset mid-operation: returns to SETUP with ptr=0, matching the filter's reset; a full flush follows.
- Flush time is at most 2^(MAX_SEL+1) clocks; o_busy is high throughout.

Optional Feature:
- Macro: SMA_DROP_CNT_EN.
- Defined:
  - Adds output o_drop_cnt [15:0], counting upstream strobes discarded while o_busy=1.
  - Saturates at 16'hFFFF; cleared on reset and on each SETUP→FLUSH transition.
  - Adds output o_flush_done, a 1-cycle pulse on FLUSH→APPLY.
- Undefined: neither port exists and no counter logic is generated.

Test Plan (MAX_SEL=4, SETTLE_CYC=3, filter instantiated alongside):
- Reset release, i_window_sel=2 → 3 setup cycles, then exactly 16 zero strobes, then 3 idle cycles with o_window_sel=2. Next, forward samples 10,20,30,40 → o_valid rises with the 4th; filter output = 25.
- In RUN at sel=2 with ptr=3, change i_window_sel to 3 → o_valid drops next cycle; flush issues 16+13=29 strobes. After priming eight samples of 8, filter output = 8 with no stale contribution.
- Constant upstream strobe during a flush → no upstream sample reaches the filter. With SMA_DROP_CNT_EN, o_drop_cnt equals the strobe count and o_flush_done pulses once.
- i_window_sel=0 → after flush, first sample 123 gives o_valid=1 and filter output 123 immediately.
- i_window_sel=20 → clamped to 4; window 16 applied; no re-flush loop.
- Assert i_rst_n low mid-FLUSH → all outputs at reset values asynchronously; on release a full 16-strobe flush restarts from ptr=0.

Source files
------------

// File: rtl/sma_window_ctrl.sv
// Window sequencer for the power-of-two SMA filter: flush, re-home, apply, prime, run.
// Optional SMA_DROP_CNT_EN adds o_drop_cnt (discarded strobes) and o_flush_done.
module sma_window_ctrl #(
    parameter int unsigned MAX_SEL    = 15,
    parameter int unsigned SETTLE_CYC = 3,
    parameter int unsigned CNT_W      = 17
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [31:0]        i_window_sel,
    input  logic               i_update_strobe,
    input  logic signed [31:0] i_data,
    output logic [31:0]        o_window_sel,
    output logic               o_update_strobe,
    output logic signed [31:0] o_data,
    output logic               o_busy,
    output logic               o_valid
`ifdef SMA_DROP_CNT_EN
    ,
    output logic [15:0]        o_drop_cnt,
    output logic               o_flush_done
`endif
);

    typedef enum logic [2:0] {S_SETUP, S_FLUSH, S_APPLY, S_PRIME, S_RUN} state_t;

    state_t             r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [CNT_W-1:0]   r_ptr, w_ptr_nxt;
    logic [31:0]        r_win_sel, w_win_sel_nxt;
    logic [31:0]        r_active_sel, w_active_sel_nxt;
    logic               r_strobe, w_strobe_nxt;
    logic               r_valid, w_valid_nxt;
    logic signed [31:0] r_data, w_data_nxt;

    logic [31:0]        w_req_sel;
    logic [31:0]        w_cur_sel;
    logic [CNT_W-1:0]   w_depth, w_cur_len, w_prime_len, w_flush_len;

    assign w_req_sel   = (i_window_sel > 32'(MAX_SEL)) ? 32'(MAX_SEL) : i_window_sel;
    assign w_depth     = CNT_W'(1) << MAX_SEL;
    assign w_prime_len = CNT_W'(1) << r_active_sel;

    // Strobes issued outside FLUSH (incl. the one forwarded on a window change)
    // hit the filter while it still runs the old, active window.
    assign w_cur_sel = (r_state == S_FLUSH) ? 32'(MAX_SEL) : r_active_sel;
    assign w_cur_len = CNT_W'(1) << w_cur_sel;
    assign w_ptr_nxt = !r_strobe ? r_ptr :
                       (r_ptr == w_cur_len - CNT_W'(1)) ? '0 : r_ptr + CNT_W'(1);

    assign w_flush_len = w_depth + ((w_depth - w_ptr_nxt) & (w_depth - CNT_W'(1)));

    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_win_sel_nxt    = r_win_sel;
        w_active_sel_nxt = r_active_sel;
        w_strobe_nxt     = 1'b0;
        w_data_nxt       = '0;
        w_valid_nxt      = r_valid;
        case (r_state)
            S_SETUP: begin
                w_win_sel_nxt = 32'(MAX_SEL);
                if (r_cnt == CNT_W'(SETTLE_CYC - 1)) begin
                    w_state_nxt  = S_FLUSH;
                    w_cnt_nxt    = w_flush_len;
                    w_strobe_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_FLUSH: begin
                if (r_cnt == CNT_W'(1)) begin
                    w_state_nxt   = S_APPLY;
                    w_cnt_nxt     = '0;
                    w_win_sel_nxt = w_req_sel;
                end else begin
                    w_cnt_nxt    = r_cnt - CNT_W'(1);
                    w_strobe_nxt = 1'b1;
                end
            end
            S_APPLY: begin
                if (r_cnt == CNT_W'(SETTLE_CYC - 1)) begin
                    w_state_nxt      = S_PRIME;
                    w_cnt_nxt        = '0;
                    w_active_sel_nxt = r_win_sel;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_PRIME, S_RUN: begin
                w_strobe_nxt = i_update_strobe;
                w_data_nxt   = i_data;
                if (w_req_sel != r_active_sel) begin
                    w_state_nxt   = S_SETUP;
                    w_cnt_nxt     = '0;
                    w_win_sel_nxt = 32'(MAX_SEL);
                    w_valid_nxt   = 1'b0;
                end else if (r_state == S_PRIME && i_update_strobe) begin
                    if (r_cnt == w_prime_len - CNT_W'(1)) begin
                        w_state_nxt = S_RUN;
                        w_valid_nxt = 1'b1;
                    end
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: w_state_nxt = S_SETUP;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_SETUP;
            r_cnt        <= '0;
            r_ptr        <= '0;
            r_win_sel    <= 32'(MAX_SEL);
            r_active_sel <= '0;
            r_strobe     <= 1'b0;
            r_data       <= '0;
            r_valid      <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_ptr        <= w_ptr_nxt;
            r_win_sel    <= w_win_sel_nxt;
            r_active_sel <= w_active_sel_nxt;
            r_strobe     <= w_strobe_nxt;
            r_data       <= w_data_nxt;
            r_valid      <= w_valid_nxt;
        end
    end

    assign o_window_sel    = r_win_sel;
    assign o_update_strobe = r_strobe;
    assign o_data          = r_data;
    assign o_valid         = r_valid;
    assign o_busy          = (r_state == S_SETUP) || (r_state == S_FLUSH) || (r_state == S_APPLY);

`ifdef SMA_DROP_CNT_EN
    logic [15:0] r_drop_cnt;
    logic        r_flush_done;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_drop_cnt   <= '0;
            r_flush_done <= 1'b0;
        end else begin
            r_flush_done <= (r_state == S_FLUSH) && (w_state_nxt == S_APPLY);
            if (r_state == S_SETUP && w_state_nxt == S_FLUSH)
                r_drop_cnt <= '0;
            else if (o_busy && i_update_strobe && r_drop_cnt != '1)
                r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

    assign o_drop_cnt   = r_drop_cnt;
    assign o_flush_done = r_flush_done;
`endif

endmodule

// File: tb/tb_sma_window_ctrl.sv
// Directed bench for sma_window_ctrl (MAX_SEL=4) with a behavioural SMA filter model
// whose sample memory starts with non-zero garbage.
module tb_sma_window_ctrl;

    localparam int unsigned MAX_SEL = 4;

    logic               clk = 1'b0;
    logic               i_rst_n;
    logic [31:0]        i_window_sel;
    logic               i_update_strobe;
    logic signed [31:0] i_data;
    logic [31:0]        o_window_sel;
    logic               o_update_strobe;
    logic signed [31:0] o_data;
    logic               o_busy;
    logic               o_valid;
`ifdef SMA_DROP_CNT_EN
    logic [15:0]        o_drop_cnt;
    logic               o_flush_done;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sma_window_ctrl #(.MAX_SEL(MAX_SEL), .SETTLE_CYC(3), .CNT_W(17)) dut (
        .i_clk           (clk),
        .i_rst_n         (i_rst_n),
        .i_window_sel    (i_window_sel),
        .i_update_strobe (i_update_strobe),
        .i_data          (i_data),
        .o_window_sel    (o_window_sel),
        .o_update_strobe (o_update_strobe),
        .o_data          (o_data),
        .o_busy          (o_busy),
        .o_valid         (o_valid)
`ifdef SMA_DROP_CNT_EN
        ,
        .o_drop_cnt      (o_drop_cnt),
        .o_flush_done    (o_flush_done)
`endif
    );

    // Filter model: circular memory without reset, 2-cycle select pipeline.
    logic signed [31:0] f_mem [16];
    logic [31:0]        f_sel_d1, f_sel_d2;
    int unsigned        f_ptr;

    initial for (int i = 0; i < 16; i++) f_mem[i] = 1000 * (i + 1);

    always @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            f_ptr    <= 0;
            f_sel_d1 <= MAX_SEL;
            f_sel_d2 <= MAX_SEL;
        end else begin
            f_sel_d1 <= o_window_sel;
            f_sel_d2 <= f_sel_d1;
            if (o_update_strobe) begin
                f_mem[f_ptr[3:0]] <= o_data;
                f_ptr <= (f_ptr == (32'd1 << f_sel_d2) - 1) ? 0 : f_ptr + 1;
            end
        end
    end

    function automatic int f_avg();
        int s = 0;
        for (int i = 0; i < (1 << f_sel_d2); i++) s += f_mem[i];
        return s >>> f_sel_d2;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    // Walks the busy period from a negedge where o_busy is high, recording what the filter sees.
    task automatic measure_busy(output int n_str, output int first, output int n_cyc,
                                output int bad, output int fd, output logic [31:0] last_win);
        n_str = 0; first = -1; n_cyc = 0; bad = 0; fd = 0; last_win = '0;
        while (o_busy && n_cyc < 200) begin
            if (o_update_strobe) begin
                n_str++;
                if (first < 0) first = n_cyc;
                if (o_data != 0) bad++;
            end
`ifdef SMA_DROP_CNT_EN
            if (o_flush_done) fd++;
`endif
            last_win = o_window_sel;
            tick();
            n_cyc++;
        end
    endtask

    int          n_str, first, n_cyc, bad, fd;
    logic [31:0] last_win;

    task automatic test_reset();
        i_rst_n = 1'b0; i_window_sel = 32'd2; i_update_strobe = 1'b0; i_data = '0;
        repeat (2) tick();
        checks++; if (o_window_sel !== 32'd4) begin errors++; $display("FAIL rst_win_sel got %0d exp 4", o_window_sel); end
        checks++; if (o_update_strobe !== 1'b0) begin errors++; $display("FAIL rst_strobe got %b exp 0", o_update_strobe); end
        checks++; if (o_data !== 32'sd0) begin errors++; $display("FAIL rst_data got %0d exp 0", o_data); end
        checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL rst_busy got %b exp 1", o_busy); end
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", o_valid); end
    endtask

    task automatic test_first_window();
        i_rst_n = 1'b1;
        measure_busy(n_str, first, n_cyc, bad, fd, last_win);
        checks++; if (first !== 3) begin errors++; $display("FAIL init_first_strobe got %0d exp 3", first); end
        checks++; if (n_str !== 16) begin errors++; $display("FAIL init_flush_len got %0d exp 16", n_str); end
        checks++; if (n_cyc !== 22) begin errors++; $display("FAIL init_busy_cycles got %0d exp 22", n_cyc); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL init_flush_data got %0d nonzero exp 0", bad); end
        checks++; if (last_win !== 32'd2) begin errors++; $display("FAIL init_apply_sel got %0d exp 2", last_win); end
        for (int k = 0; k < 4; k++) begin
            i_update_strobe = 1'b1; i_data = 10 * (k + 1);
            tick();
            checks++; if (o_valid !== (k == 3)) begin errors++; $display("FAIL prime4_valid[%0d] got %b exp %b", k, o_valid, k == 3); end
        end
        i_update_strobe = 1'b0;
        tick();
        checks++; if (f_avg() !== 25) begin errors++; $display("FAIL prime4_avg got %0d exp 25", f_avg()); end
    endtask

    task automatic test_window_change();
        for (int k = 0; k < 3; k++) begin
            i_update_strobe = 1'b1; i_data = 50 + 10 * k;
            tick();
        end
        i_update_strobe = 1'b0;
        tick();
        checks++; if (f_avg() !== 55) begin errors++; $display("FAIL run_avg got %0d exp 55", f_avg()); end
        checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL run_valid got %b exp 1", o_valid); end
        i_window_sel = 32'd3;
        tick();
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL chg_valid_drop got %b exp 0", o_valid); end
        measure_busy(n_str, first, n_cyc, bad, fd, last_win);
        checks++; if (n_str !== 29) begin errors++; $display("FAIL chg_flush_len got %0d exp 29", n_str); end
        checks++; if (n_cyc !== 35) begin errors++; $display("FAIL chg_busy_cycles got %0d exp 35", n_cyc); end
        checks++; if (last_win !== 32'd3) begin errors++; $display("FAIL chg_apply_sel got %0d exp 3", last_win); end
        for (int k = 0; k < 8; k++) begin
            i_update_strobe = 1'b1; i_data = 8;
            tick();
            checks++; if (o_valid !== (k == 7)) begin errors++; $display("FAIL prime8_valid[%0d] got %b exp %b", k, o_valid, k == 7); end
        end
        i_update_strobe = 1'b0;
        tick();
        checks++; if (f_avg() !== 8) begin errors++; $display("FAIL prime8_avg got %0d exp 8", f_avg()); end
    endtask

    task automatic test_drop_and_window0();
        i_window_sel = 32'd0;
        tick();
        i_update_strobe = 1'b1; i_data = 77;
        measure_busy(n_str, first, n_cyc, bad, fd, last_win);
        checks++; if (n_str !== 16) begin errors++; $display("FAIL drop_flush_len got %0d exp 16", n_str); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL drop_leak got %0d nonzero exp 0", bad); end
`ifdef SMA_DROP_CNT_EN
        checks++; if (o_drop_cnt !== 16'd19) begin errors++; $display("FAIL drop_cnt got %0d exp 19", o_drop_cnt); end
        checks++; if (fd !== 1) begin errors++; $display("FAIL flush_done_pulses got %0d exp 1", fd); end
`endif
        i_data = 123;
        tick();
        i_update_strobe = 1'b0;
        checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL w0_valid got %b exp 1", o_valid); end
        checks++; if (o_data !== 32'sd123) begin errors++; $display("FAIL w0_data got %0d exp 123", o_data); end
        tick();
        checks++; if (f_avg() !== 123) begin errors++; $display("FAIL w0_avg got %0d exp 123", f_avg()); end
`ifdef SMA_DROP_CNT_EN
        checks++; if (o_drop_cnt !== 16'd19) begin errors++; $display("FAIL drop_cnt_hold got %0d exp 19", o_drop_cnt); end
`endif
    endtask

    task automatic test_clamp();
        int busy_cnt = 0;
        i_window_sel = 32'd20;
        tick();
        measure_busy(n_str, first, n_cyc, bad, fd, last_win);
        checks++; if (n_str !== 16) begin errors++; $display("FAIL clamp_flush_len got %0d exp 16", n_str); end
        checks++; if (last_win !== 32'd4) begin errors++; $display("FAIL clamp_sel got %0d exp 4", last_win); end
        for (int k = 0; k < 10; k++) begin
            if (o_busy) busy_cnt++;
            tick();
        end
        checks++; if (busy_cnt !== 0) begin errors++; $display("FAIL clamp_reflush got %0d busy cycles exp 0", busy_cnt); end
    endtask

    task automatic test_reset_mid_flush();
        i_window_sel = 32'd1;
        tick();
        repeat (8) tick();
        checks++; if (o_update_strobe !== 1'b1) begin errors++; $display("FAIL mid_flush_strobe got %b exp 1", o_update_strobe); end
        #2 i_rst_n = 1'b0;
        #1;
        checks++; if (o_window_sel !== 32'd4) begin errors++; $display("FAIL arst_win_sel got %0d exp 4", o_window_sel); end
        checks++; if (o_update_strobe !== 1'b0) begin errors++; $display("FAIL arst_strobe got %b exp 0", o_update_strobe); end
        checks++; if (o_busy !== 1'b1 || o_valid !== 1'b0) begin errors++; $display("FAIL arst_busy_valid got %b%b exp 10", o_busy, o_valid); end
        tick();
        i_rst_n = 1'b1;
        measure_busy(n_str, first, n_cyc, bad, fd, last_win);
        checks++; if (first !== 3) begin errors++; $display("FAIL arst_first_strobe got %0d exp 3", first); end
        checks++; if (n_str !== 16) begin errors++; $display("FAIL arst_flush_len got %0d exp 16", n_str); end
        checks++; if (last_win !== 32'd1) begin errors++; $display("FAIL arst_apply_sel got %0d exp 1", last_win); end
        i_update_strobe = 1'b1; i_data = 6;
        tick();
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL w1_valid_early got %b exp 0", o_valid); end
        i_data = 8;
        tick();
        checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL w1_valid got %b exp 1", o_valid); end
        i_update_strobe = 1'b0;
        tick();
        checks++; if (f_avg() !== 7) begin errors++; $display("FAIL w1_avg got %0d exp 7", f_avg()); end
    endtask

    initial begin
        test_reset();
        test_first_window();
        test_window_change();
        test_drop_and_window0();
        test_clamp();
        test_reset_mid_flush();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
